axi_puf_seq_master: RTL and testbench

- AXI4-Lite initiator that programs and runs an LFSR/PUF register-slave peripheral without CPU involvement.
- On a start pulse it writes seed, polynomial and count, then writes the run register, polls state until idle, and reads back the LFSR output Q.
- Sits between local control logic and the peripheral's s_axi port.

---
 rtl/axi_puf_seq_master_if.sv | 38 +++
 rtl/axi_puf_seq_master.sv | 262 ++++++++++++++++++++++++++
 tb/tb_axi_puf_seq_master.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_puf_seq_master_if.sv
// AXI4-Lite bundle between axi_puf_seq_master (master side) and the LFSR/PUF peripheral (slave side).
interface axi_puf_seq_master_if;
    logic        awvalid;
    logic [15:0] awaddr;
    logic [2:0]  awprot;
    logic        awready;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        bready;
    logic        arvalid;
    logic [15:0] araddr;
    logic [2:0]  arprot;
    logic        arready;
    logic        rvalid;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    logic        rready;

    modport master (
        output awvalid, awaddr, awprot, input awready,
        output wvalid, wdata, wstrb, input wready,
        input bvalid, bresp, output bready,
        output arvalid, araddr, arprot, input arready,
        input rvalid, rresp, rdata, output rready
    );

    modport slave (
        input awvalid, awaddr, awprot, output awready,
        input wvalid, wdata, wstrb, output wready,
        output bvalid, bresp, input bready,
        input arvalid, araddr, arprot, output arready,
        output rvalid, rresp, rdata, input rready
    );
endinterface

// File: rtl/axi_puf_seq_master.sv
// AXI4-Lite sequencer: programs seed/poly/cnt, runs the LFSR/PUF peripheral, polls until idle, reads Q.
// Define AXI_PUF_SEQ_MAGIC_CHECK_EN to verify the peripheral magic word before any write.
module axi_puf_seq_master #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int unsigned POLL_MAX  = 1024
) (
    input  logic                  m_axi_aclk,
    input  logic                  m_axi_aresetn,
    input  logic                  start,
    input  logic [31:0]           seed_in,
    input  logic [31:0]           poly_in,
    input  logic [31:0]           cnt_in,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [31:0]           q_out,
    axi_puf_seq_master_if.master  m_axi
);

    localparam logic [15:0] OFF_MAGIC = 16'h0008;
    localparam logic [15:0] OFF_SEED  = 16'h000C;
    localparam logic [15:0] OFF_POLY  = 16'h0010;
    localparam logic [15:0] OFF_CNT   = 16'h0014;
    localparam logic [15:0] OFF_Q     = 16'h0018;
    localparam logic [15:0] OFF_RUN   = 16'h001C;

    localparam logic [31:0] MAGIC_VALUE = 32'h4746_5550;
    localparam logic [31:0] STATE_IDLE  = 32'h0000_0001;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_RESP    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_MAGIC   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef AXI_PUF_SEQ_MAGIC_CHECK_EN
        S_CHK_MAGIC,
`endif
        S_WR_SEED,
        S_WR_POLY,
        S_WR_CNT,
        S_WR_RUN,
        S_POLL,
        S_RD_Q
    } state_e;

`ifdef AXI_PUF_SEQ_MAGIC_CHECK_EN
    localparam state_e FIRST_STEP = S_CHK_MAGIC;
`else
    localparam state_e FIRST_STEP = S_WR_SEED;
`endif

    function automatic logic is_write(input state_e s);
        return (s == S_WR_SEED) || (s == S_WR_POLY) || (s == S_WR_CNT) || (s == S_WR_RUN);
    endfunction

    state_e      state_q, state_d;
    logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic        arvalid_q, arvalid_d, rready_q, rready_d;
    logic        busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [31:0] q_q, q_d, seed_q, seed_d, poly_q, poly_d, cnt_q, cnt_d;
    logic [31:0] poll_cnt_q, poll_cnt_d, poll_inc;
    logic        advance, abort;
    state_e      next_step;
    logic [1:0]  abort_code;
    logic [15:0] offset;
    logic [31:0] wdata;

    // NOTE: registers use non-blocking <= so every flop samples pre-edge values;
    // the async reset also drops all valids the moment m_axi_aresetn falls.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q    <= S_IDLE;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            q_q        <= '0;
            seed_q     <= '0;
            poly_q     <= '0;
            cnt_q      <= '0;
            poll_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            q_q        <= q_d;
            seed_q     <= seed_d;
            poly_q     <= poly_d;
            cnt_q      <= cnt_d;
            poll_cnt_q <= poll_cnt_d;
        end
    end

    assign poll_inc = (poll_cnt_q == '1) ? poll_cnt_q : poll_cnt_q + 32'd1;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        err_code_d = err_code_q;
        q_d        = q_q;
        seed_d     = seed_q;
        poly_d     = poly_q;
        cnt_d      = cnt_q;
        poll_cnt_d = poll_cnt_q;
        advance    = 1'b0;
        next_step  = state_q;
        abort      = 1'b0;
        abort_code = ERR_NONE;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    seed_d     = seed_in;
                    poly_d     = poly_in;
                    cnt_d      = cnt_in;
                    busy_d     = 1'b1;
                    err_code_d = ERR_NONE;
                    poll_cnt_d = '0;
                    advance    = 1'b1;
                    next_step  = FIRST_STEP;
                end
            end
            S_WR_SEED, S_WR_POLY, S_WR_CNT, S_WR_RUN: begin
                if (awvalid_q && m_axi.awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi.wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d && !bready_q) bready_d = 1'b1;
                if (bready_q && m_axi.bvalid) begin
                    bready_d = 1'b0;
                    if (m_axi.bresp != 2'b00) begin
                        abort      = 1'b1;
                        abort_code = ERR_RESP;
                    end else begin
                        advance = 1'b1;
                        case (state_q)
                            S_WR_SEED: next_step = S_WR_POLY;
                            S_WR_POLY: next_step = S_WR_CNT;
                            S_WR_CNT:  next_step = S_WR_RUN;
                            default:   next_step = S_POLL;
                        endcase
                    end
                end
            end
`ifdef AXI_PUF_SEQ_MAGIC_CHECK_EN
            S_CHK_MAGIC,
`endif
            S_POLL, S_RD_Q: begin
                if (arvalid_q && m_axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
                if (rready_q && m_axi.rvalid) begin
                    rready_d = 1'b0;
                    if (m_axi.rresp != 2'b00) begin
                        abort      = 1'b1;
                        abort_code = ERR_RESP;
                    end else if (state_q == S_POLL) begin
                        poll_cnt_d = poll_inc;
                        if (m_axi.rdata == STATE_IDLE) begin
                            advance   = 1'b1;
                            next_step = S_RD_Q;
                        end else if (poll_inc >= POLL_MAX) begin
                            abort      = 1'b1;
                            abort_code = ERR_TIMEOUT;
                        end else begin
                            arvalid_d = 1'b1;   // back-to-back status read, no idle cycle
                        end
                    end else if (state_q == S_RD_Q) begin
                        q_d     = m_axi.rdata;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
`ifdef AXI_PUF_SEQ_MAGIC_CHECK_EN
                    else if (m_axi.rdata == MAGIC_VALUE) begin
                        advance   = 1'b1;
                        next_step = S_WR_SEED;
                    end else begin
                        abort      = 1'b1;
                        abort_code = ERR_MAGIC;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            state_d = next_step;
            if (is_write(next_step)) begin
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
            end else begin
                arvalid_d = 1'b1;
            end
        end

        if (abort) begin
            state_d    = S_IDLE;
            error_d    = 1'b1;
            err_code_d = abort_code;
            busy_d     = 1'b0;
        end
    end

    always_comb begin
        offset = OFF_RUN;
        wdata  = 32'h0000_0001;
        case (state_q)
            S_WR_SEED: begin offset = OFF_SEED; wdata = seed_q; end
            S_WR_POLY: begin offset = OFF_POLY; wdata = poly_q; end
            S_WR_CNT:  begin offset = OFF_CNT;  wdata = cnt_q;  end
            S_RD_Q:    offset = OFF_Q;
`ifdef AXI_PUF_SEQ_MAGIC_CHECK_EN
            S_CHK_MAGIC: offset = OFF_MAGIC;
`endif
            default: ;
        endcase
    end

    assign m_axi.awvalid = awvalid_q;
    assign m_axi.awaddr  = BASE_ADDR + offset;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.wdata   = wdata;
    assign m_axi.wstrb   = 4'hF;
    assign m_axi.bready  = bready_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.araddr  = BASE_ADDR + offset;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.rready  = rready_q;

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign err_code = err_code_q;
    assign q_out    = q_q;

endmodule

// File: tb/tb_axi_puf_seq_master.sv
// Directed bench for axi_puf_seq_master with a negedge-driven AXI4-Lite peripheral model.
// BASE_ADDR=0xFFF0 so several register addresses wrap past 0xFFFF.
module tb_axi_puf_seq_master;

    localparam logic [15:0] A_MAGIC = 16'hFFF8;
    localparam logic [15:0] A_SEED  = 16'hFFFC;
    localparam logic [15:0] A_POLY  = 16'h0000;
    localparam logic [15:0] A_CNT   = 16'h0004;
    localparam logic [15:0] A_Q     = 16'h0008;
    localparam logic [15:0] A_RUN   = 16'h000C;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] seed_in, poly_in, cnt_in;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [31:0] q_out;

    axi_puf_seq_master_if bus ();

    axi_puf_seq_master #(.BASE_ADDR(16'hFFF0), .POLL_MAX(4)) dut (
        .m_axi_aclk    (clk),
        .m_axi_aresetn (rst_n),
        .start         (start),
        .seed_in       (seed_in),
        .poly_in       (poly_in),
        .cnt_in        (cnt_in),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .err_code      (err_code),
        .q_out         (q_out),
        .m_axi         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Peripheral model configuration (written by the stimulus process only)
    logic [31:0] q_val      = 32'hDEAD_BEEF;
    logic [31:0] magic_val  = 32'h4746_5550;
    int          idle_after = 0;
    bit          bad_b_en   = 0;
    logic [15:0] bad_b_addr = 16'h0;
    int          w_delay    = 0;
    logic [15:0] w_dly_addr = 16'h0;

    // Observations
    logic [15:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int n_aw, n_rd_state, n_rd_magic, poll_idx, wonly_cnt, done_cnt, error_cnt;

    // Model state
    bit          aw_v_prev, w_v_prev, b_r_prev, ar_v_prev, r_r_prev;
    logic [15:0] aw_a_prev, ar_a_prev, aw_addr;
    logic [31:0] w_d_prev, w_data;
    bit          aw_done, w_done;
    int          wcnt;

    // Handshakes are recognised at the negedge after the posedge they happened on:
    // valids seen at the previous negedge plus readies still held from it.
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
            bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rresp = 2'b00; bus.rdata = 32'h0;
            aw_v_prev = 0; w_v_prev = 0; b_r_prev = 0; ar_v_prev = 0; r_r_prev = 0;
            aw_done = 0; w_done = 0; wcnt = 0;
        end else begin
            if (aw_v_prev && bus.awready) begin
                aw_done = 1; aw_addr = aw_a_prev; n_aw++;
            end
            if (w_v_prev && bus.wready) begin
                w_done = 1; w_data = w_d_prev; wcnt = 0;
            end
            if (bus.bvalid && b_r_prev) begin
                bus.bvalid = 1'b0;
                wr_addr_q.push_back(aw_addr);
                wr_data_q.push_back(w_data);
                aw_done = 0; w_done = 0;
            end else if (aw_done && w_done && !bus.bvalid) begin
                bus.bvalid = 1'b1;
                bus.bresp  = (bad_b_en && aw_addr == bad_b_addr) ? 2'b10 : 2'b00;
            end
            if (bus.rvalid && r_r_prev) bus.rvalid = 1'b0;
            if (ar_v_prev && bus.arready) begin
                bus.rvalid = 1'b1;
                bus.rresp  = 2'b00;
                if (ar_a_prev == A_RUN) begin
                    bus.rdata = (poll_idx < idle_after) ? 32'h8 : 32'h1;
                    poll_idx++; n_rd_state++;
                end else if (ar_a_prev == A_Q) begin
                    bus.rdata = q_val;
                end else if (ar_a_prev == A_MAGIC) begin
                    bus.rdata = magic_val; n_rd_magic++;
                end else begin
                    bus.rdata = 32'h0;
                end
            end
            bus.awready = bus.awvalid;
            bus.arready = bus.arvalid;
            if (bus.wvalid && bus.awaddr == w_dly_addr && wcnt < w_delay) begin
                wcnt++;
                bus.wready = 1'b0;
            end else begin
                bus.wready = bus.wvalid;
            end
            if (bus.wvalid && !bus.awvalid) wonly_cnt++;
            aw_v_prev = bus.awvalid; aw_a_prev = bus.awaddr;
            w_v_prev  = bus.wvalid;  w_d_prev  = bus.wdata;
            b_r_prev  = bus.bready;
            ar_v_prev = bus.arvalid; ar_a_prev = bus.araddr;
            r_r_prev  = bus.rready;
        end
    end

    always @(negedge clk) begin
        if (done)  done_cnt++;
        if (error) error_cnt++;
    end

    task automatic clear_obs();
        wr_addr_q.delete(); wr_data_q.delete();
        n_aw = 0; n_rd_state = 0; n_rd_magic = 0; poll_idx = 0;
        wonly_cnt = 0; done_cnt = 0; error_cnt = 0;
    endtask

    task automatic start_seq(input string tag, input logic [31:0] s, input logic [31:0] p,
                             input logic [31:0] c);
        clear_obs();
        @(negedge clk);
        seed_in = s; poly_in = p; cnt_in = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy after start"}, {31'b0, busy}, 32'h1);
    endtask

    task automatic wait_end(input string tag);
        bit hit = 0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            if (done || error) hit = 1;
        end
        check({tag, " finished in budget"}, {31'b0, hit}, 32'h1);
        if (hit) check({tag, " busy low at end"}, {31'b0, busy}, 32'h0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_writes(input string tag, input logic [31:0] s, input logic [31:0] p,
                                input logic [31:0] c);
        logic [15:0] ea[4];
        logic [31:0] ed[4];
        ea = '{A_SEED, A_POLY, A_CNT, A_RUN};
        ed = '{s, p, c, 32'h1};
        check({tag, " write count"}, wr_addr_q.size(), 32'd4);
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            check($sformatf("%s wr%0d addr", tag, i), {16'h0, wr_addr_q[i]}, {16'h0, ea[i]});
            check($sformatf("%s wr%0d data", tag, i), wr_data_q[i], ed[i]);
        end
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; start = 1'b0; seed_in = '0; poly_in = '0; cnt_in = '0;
        clear_obs();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst busy",     {31'b0, busy},        32'h0);
        check("rst done",     {31'b0, done},        32'h0);
        check("rst error",    {31'b0, error},       32'h0);
        check("rst err_code", {30'b0, err_code},    32'h0);
        check("rst q_out",    q_out,                32'h0);
        check("rst awvalid",  {31'b0, bus.awvalid}, 32'h0);
        check("rst wvalid",   {31'b0, bus.wvalid},  32'h0);
        check("rst arvalid",  {31'b0, bus.arvalid}, 32'h0);
        check("rst bready",   {31'b0, bus.bready},  32'h0);
        check("rst rready",   {31'b0, bus.rready},  32'h0);

        // 1: nominal run, two busy polls then idle; a start while busy is dropped
        idle_after = 2; q_val = 32'hDEAD_BEEF;
        start_seq("t1", 32'h1, 32'h8020_0003, 32'd4);
        @(negedge clk);
        seed_in = 32'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end("t1");
        check_writes("t1", 32'h1, 32'h8020_0003, 32'd4);
        check("t1 status reads", n_rd_state, 32'd3);
        check("t1 q_out",        q_out,      32'hDEAD_BEEF);
        check("t1 done pulses",  done_cnt,   32'd1);
        check("t1 error pulses", error_cnt,  32'd0);
        check("t1 err_code",     {30'b0, err_code}, 32'h0);
        check("t1 magic reads",
`ifdef AXI_PUF_SEQ_MAGIC_CHECK_EN
              n_rd_magic, 32'd1);
`else
              n_rd_magic, 32'd0);
`endif

        // 2: wready held off 5 cycles on the seed write
        w_delay = 5; w_dly_addr = A_SEED; idle_after = 0; q_val = 32'h1234_5678;
        start_seq("t2", 32'hA5A5_0001, 32'h0000_00C3, 32'd100);
        wait_end("t2");
        w_delay = 0;
        check("t2 wvalid-only cycles", wonly_cnt, 32'd5);
        check_writes("t2", 32'hA5A5_0001, 32'h0000_00C3, 32'd100);
        check("t2 q_out",       q_out,    32'h1234_5678);
        check("t2 done pulses", done_cnt, 32'd1);

        // 3: SLVERR on the poly write aborts before the cnt write
        bad_b_en = 1; bad_b_addr = A_POLY; q_val = 32'hFFFF_FFFF;
        start_seq("t3", 32'h2, 32'h3, 32'h5);
        wait_end("t3");
        bad_b_en = 0;
        check("t3 aw count",     n_aw,              32'd2);
        check("t3 error pulses", error_cnt,         32'd1);
        check("t3 done pulses",  done_cnt,          32'd0);
        check("t3 err_code",     {30'b0, err_code}, 32'h1);
        check("t3 q_out kept",   q_out,             32'h1234_5678);

        // 4: never idle -> POLL_MAX=4 status reads then timeout
        idle_after = 1000;
        start_seq("t4", 32'h4, 32'h5, 32'h6);
        wait_end("t4");
        check("t4 status reads", n_rd_state,        32'd4);
        check("t4 error pulses", error_cnt,         32'd1);
        check("t4 err_code",     {30'b0, err_code}, 32'h2);
        check("t4 q_out kept",   q_out,             32'h1234_5678);

`ifdef AXI_PUF_SEQ_MAGIC_CHECK_EN
        // 5: magic mismatch aborts before any write; correct magic runs normally
        magic_val = 32'h1234_5678;
        start_seq("t5a", 32'h7, 32'h7, 32'h7);
        wait_end("t5a");
        check("t5a aw count",    n_aw,              32'd0);
        check("t5a err_code",    {30'b0, err_code}, 32'h3);
        check("t5a error pulse", error_cnt,         32'd1);
        magic_val = 32'h4746_5550; idle_after = 1; q_val = 32'h0BAD_F00D;
        start_seq("t5b", 32'h9, 32'hA, 32'hB);
        wait_end("t5b");
        check_writes("t5b", 32'h9, 32'hA, 32'hB);
        check("t5b q_out", q_out, 32'h0BAD_F00D);
`endif

        // 6: reset during the cnt write address phase, then a clean run
        idle_after = 1; q_val = 32'hCAFE_F00D;
        start_seq("t6", 32'h7, 32'h8, 32'h9);
        found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            if (bus.awvalid && bus.awaddr == A_CNT) found = 1;
        end
        check("t6 reached cnt write", {31'b0, found}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("t6 awvalid in reset", {31'b0, bus.awvalid}, 32'h0);
        check("t6 wvalid in reset",  {31'b0, bus.wvalid},  32'h0);
        check("t6 busy in reset",    {31'b0, busy},        32'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("t6 q_out after reset", q_out, 32'h0);
        start_seq("t6b", 32'h11, 32'h22, 32'h33);
        wait_end("t6b");
        check_writes("t6b", 32'h11, 32'h22, 32'h33);
        check("t6b q_out",       q_out,    32'hCAFE_F00D);
        check("t6b done pulses", done_cnt, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
